ecall_halt_unit: RTL and testbench

//   Response side of the ecall path. The ID stage reads x17 through the ecall

---
 rtl/ecall_halt_unit_if.sv | 31 +++
 rtl/ecall_halt_unit.sv | 99 +++++++++
 tb/tb_ecall_halt_unit.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecall_halt_unit_if.sv
// ecall_halt_unit_if
//   Bundles the ID-stage ecall signals and the halt-unit responses.
//   master : ID stage / testbench side (drives ID signals, observes responses)
//   slave  : ecall_halt_unit side (observes ID signals, drives responses)
//   Signals:
//     id_valid, id_is_ecall, id_stall, id_flush, id_x17_data  (ID -> unit)
//     halt_detect, halt_pending, is_halted, ecall_count        (unit -> ID/tb)
interface ecall_halt_unit_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) ();
  logic             id_valid;
  logic             id_is_ecall;
  logic             id_stall;
  logic             id_flush;
  logic [XLEN-1:0]  id_x17_data;
  logic             halt_detect;
  logic             halt_pending;
  logic             is_halted;
  logic [CNT_W-1:0] ecall_count;

  modport master (
    output id_valid, id_is_ecall, id_stall, id_flush, id_x17_data,
    input  halt_detect, halt_pending, is_halted, ecall_count
  );

  modport slave (
    input  id_valid, id_is_ecall, id_stall, id_flush, id_x17_data,
    output halt_detect, halt_pending, is_halted, ecall_count
  );
endinterface

// File: rtl/ecall_halt_unit.sv
// ecall_halt_unit
//   Decides whether an ecall seen in ID halts the CPU. A halting ecall
//   (x17 == HALT_CODE) freezes fetch while in-flight instructions drain for
//   DRAIN_CYCLES cycles, then raises a sticky is_halted. Accepted ecalls with
//   any other x17 value are counted (saturating) for debug.
//   Ports:
//     clk    : rising-edge clock
//     reset  : asynchronous active-low reset
//     bus    : ecall_halt_unit_if.slave
//              in : id_valid, id_is_ecall, id_stall, id_flush, id_x17_data
//              out: halt_detect (comb), halt_pending, is_halted, ecall_count
module ecall_halt_unit #(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned HALT_CODE    = 10,
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  ecall_halt_unit_if.slave        bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic accept;
  logic is_halt_code;
  logic detect;

  always_comb begin
    accept       = bus.id_valid & bus.id_is_ecall & ~bus.id_stall & ~bus.id_flush;
    is_halt_code = (bus.id_x17_data == XLEN'(HALT_CODE));
    detect       = (state_q == RUN) & accept & is_halt_code;
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    unique case (state_q)
      RUN: begin
        if (detect) begin
          if (DRAIN_CYCLES == 0) begin
            state_d = HALTED;
          end else begin
            state_d = DRAIN;
            cnt_d   = 4'(DRAIN_CYCLES);
          end
        end else if (accept && (count_q != '1)) begin
          count_d = count_q + 1'b1;
        end
      end
      DRAIN: begin
        cnt_d = cnt_q - 4'd1;
        // <= rather than == so a zero count can never wrap into a long drain
        if (cnt_q <= 4'd1) begin
          state_d = HALTED;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = RUN;
        cnt_d   = '0;
      end
    endcase
  end

  // Output logic: pending/halted decode straight from the state flop
  always_comb begin
    bus.halt_detect  = detect;
    bus.halt_pending = (state_q == DRAIN);
    bus.is_halted    = (state_q == HALTED);
    bus.ecall_count  = count_q;
  end

endmodule

// File: tb/tb_ecall_halt_unit.sv
module tb_ecall_halt_unit;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  ecall_halt_unit_if #(.XLEN(32), .CNT_W(16)) if0 ();
  ecall_halt_unit_if #(.XLEN(32), .CNT_W(4))  if1 ();

  ecall_halt_unit #(
    .XLEN(32), .HALT_CODE(10), .DRAIN_CYCLES(3), .CNT_W(16)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(if0)
  );

  ecall_halt_unit #(
    .XLEN(32), .HALT_CODE(10), .DRAIN_CYCLES(0), .CNT_W(4)
  ) u_dut0 (
    .clk(clk), .reset(reset), .bus(if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive0(input logic v, input logic e, input logic s,
                        input logic f, input logic [31:0] x);
    if0.id_valid    = v;
    if0.id_is_ecall = e;
    if0.id_stall    = s;
    if0.id_flush    = f;
    if0.id_x17_data = x;
  endtask

  task automatic drive1(input logic v, input logic e, input logic [31:0] x);
    if1.id_valid    = v;
    if1.id_is_ecall = e;
    if1.id_stall    = 1'b0;
    if1.id_flush    = 1'b0;
    if1.id_x17_data = x;
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    drive1(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({if0.halt_detect, if0.halt_pending, if0.is_halted} !== 3'b000 || if0.ecall_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_outputs got det=%b pend=%b halt=%b cnt=%0d exp all 0",
               if0.halt_detect, if0.halt_pending, if0.is_halted, if0.ecall_count);
    end
    checks++;
    if ({if1.halt_pending, if1.is_halted} !== 2'b00 || if1.ecall_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_outputs_d0 got pend=%b halt=%b cnt=%0d exp all 0",
               if1.halt_pending, if1.is_halted, if1.ecall_count);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Halt ecall in cycle 5 after reset: pending 3 cycles, then sticky halted
  task automatic test_halt_latency();
    test_reset();
    for (int i = 0; i < 4; i++) step();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd10);
    @(negedge clk);
    checks++;
    if (if0.halt_detect !== 1'b1 || if0.halt_pending !== 1'b0) begin
      errors++;
      $display("FAIL t1_detect got det=%b pend=%b exp det=1 pend=0", if0.halt_detect, if0.halt_pending);
    end
    step();
    // Keep ecalls arriving during drain: they must be ignored and uncounted
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (if0.halt_pending !== 1'b1 || if0.is_halted !== 1'b0 || if0.halt_detect !== 1'b0) begin
        errors++;
        $display("FAIL t1_drain%0d got pend=%b halt=%b det=%b exp pend=1 halt=0 det=0",
                 i, if0.halt_pending, if0.is_halted, if0.halt_detect);
      end
      if (i == 2) drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd10);
      step();
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (if0.is_halted !== 1'b1 || if0.halt_pending !== 1'b0 || if0.halt_detect !== 1'b0) begin
        errors++;
        $display("FAIL t1_halted%0d got halt=%b pend=%b det=%b exp halt=1 pend=0 det=0",
                 i, if0.is_halted, if0.halt_pending, if0.halt_detect);
      end
      step();
    end
    checks++;
    if (if0.ecall_count !== 16'd0) begin
      errors++;
      $display("FAIL t1_no_count got=%0d exp=0", if0.ecall_count);
    end
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic test_count();
    test_reset();
    for (int i = 0; i < 3; i++) begin
      step();
      drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
      @(negedge clk);
      checks++;
      if (if0.halt_detect !== 1'b0) begin
        errors++;
        $display("FAIL t2_detect%0d got=%b exp=0", i, if0.halt_detect);
      end
      step();
      // Bubble carrying a stale ecall flag must not count
      drive0(1'b0, 1'b1, 1'b0, 1'b0, 32'd4);
    end
    step();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checks++;
    if (if0.ecall_count !== 16'd3 || if0.halt_pending !== 1'b0 || if0.is_halted !== 1'b0) begin
      errors++;
      $display("FAIL t2_count got cnt=%0d pend=%b halt=%b exp cnt=3 pend=0 halt=0",
               if0.ecall_count, if0.halt_pending, if0.is_halted);
    end
  endtask

  task automatic test_stall();
    test_reset();
    step();
    drive0(1'b1, 1'b1, 1'b1, 1'b0, 32'd10);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (if0.halt_detect !== 1'b0) begin
        errors++;
        $display("FAIL t3_stall_detect%0d got=%b exp=0", i, if0.halt_detect);
      end
      step();
    end
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd10);
    @(negedge clk);
    checks++;
    if (if0.halt_detect !== 1'b1) begin
      errors++;
      $display("FAIL t3_detect got=%b exp=1", if0.halt_detect);
    end
    step();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++;
      if (if0.is_halted !== (i == 4)) begin
        errors++;
        $display("FAIL t3_halt_cycle%0d got=%b exp=%b", i, if0.is_halted, (i == 4));
      end
      step();
    end
  endtask

  task automatic test_flush();
    test_reset();
    step();
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 32'd10);
    @(negedge clk);
    checks++;
    if (if0.halt_detect !== 1'b0) begin
      errors++;
      $display("FAIL t4_flush_detect got=%b exp=0", if0.halt_detect);
    end
    step();
    drive0(1'b1, 1'b1, 1'b0, 1'b1, 32'd4);
    step();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checks++;
    if (if0.halt_pending !== 1'b0 || if0.is_halted !== 1'b0 || if0.ecall_count !== 16'd0) begin
      errors++;
      $display("FAIL t4_flush_state got pend=%b halt=%b cnt=%0d exp 0 0 0",
               if0.halt_pending, if0.is_halted, if0.ecall_count);
    end
    // Still in RUN: an ordinary ecall is counted
    step();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd4);
    step();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checks++;
    if (if0.ecall_count !== 16'd1) begin
      errors++;
      $display("FAIL t4_run_count got=%0d exp=1", if0.ecall_count);
    end
  endtask

  task automatic test_reset_mid_drain();
    test_reset();
    step();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd7);
    step();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd10);
    step();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    step();
    // Now in the 2nd drain cycle
    #2;
    checks++;
    if (if0.halt_pending !== 1'b1 || if0.ecall_count !== 16'd1) begin
      errors++;
      $display("FAIL t5_pre got pend=%b cnt=%0d exp pend=1 cnt=1", if0.halt_pending, if0.ecall_count);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (if0.halt_pending !== 1'b0 || if0.is_halted !== 1'b0 || if0.ecall_count !== 16'd0) begin
      errors++;
      $display("FAIL t5_async got pend=%b halt=%b cnt=%0d exp 0 0 0",
               if0.halt_pending, if0.is_halted, if0.ecall_count);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      @(negedge clk);
      checks++;
      if (if0.is_halted !== 1'b0 || if0.halt_pending !== 1'b0) begin
        errors++;
        $display("FAIL t5_no_halt%0d got halt=%b pend=%b exp 0 0", i, if0.is_halted, if0.halt_pending);
      end
    end
    step();
    drive0(1'b1, 1'b1, 1'b0, 1'b0, 32'd10);
    @(negedge clk);
    checks++;
    if (if0.halt_detect !== 1'b1) begin
      errors++;
      $display("FAIL t5_redetect got=%b exp=1", if0.halt_detect);
    end
    step();
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    checks++;
    if (if0.is_halted !== 1'b1 || if0.halt_pending !== 1'b0) begin
      errors++;
      $display("FAIL t5_rehalt got halt=%b pend=%b exp halt=1 pend=0", if0.is_halted, if0.halt_pending);
    end
  endtask

  task automatic test_zero_drain_saturate();
    test_reset();
    step();
    drive1(1'b1, 1'b1, 32'd4);
    for (int i = 0; i < 17; i++) step();
    drive1(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    checks++;
    if (if1.ecall_count !== 4'hF) begin
      errors++;
      $display("FAIL t6_saturate got=%0d exp=15", if1.ecall_count);
    end
    step();
    drive1(1'b1, 1'b1, 32'd10);
    @(negedge clk);
    checks++;
    if (if1.halt_detect !== 1'b1 || if1.halt_pending !== 1'b0) begin
      errors++;
      $display("FAIL t6_detect got det=%b pend=%b exp det=1 pend=0", if1.halt_detect, if1.halt_pending);
    end
    step();
    drive1(1'b0, 1'b0, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (if1.is_halted !== 1'b1 || if1.halt_pending !== 1'b0 || if1.ecall_count !== 4'hF) begin
        errors++;
        $display("FAIL t6_halted%0d got halt=%b pend=%b cnt=%0d exp halt=1 pend=0 cnt=15",
                 i, if1.is_halted, if1.halt_pending, if1.ecall_count);
      end
      step();
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    drive0(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    drive1(1'b0, 1'b0, 32'd0);
    test_reset();
    test_halt_latency();
    test_count();
    test_stall();
    test_flush();
    test_reset_mid_drain();
    test_zero_drain_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
